axi_line_master: RTL and testbench
==================================

Name: axi_line_master

Overview:
- Parametrised AXI3 burst master between the cache controller and the AXI interconnect.
- Read refill: one INCR burst of LINE_WORDS 32-bit words per request, streamed to the cache.
- Write-back: reads line words from the cache array by index and issues a full INCR write burst with B-response tracking.
- Independent read and write engines, one outstanding transaction each. A read to the line currently being written back is held off.

Parameters:
- LINE_WORDS, 8, words per line/burst; power of two, 2..16 (AXI3 len limit)
- RD_ID, 0, arid value
- WR_ID, 1, awid and wid value

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-high (1 = reset)
- rd_req  in  1  refill request; level, held until rd_ack
- rd_addr  in  32  refill byte address
- rd_ack  out  1  1-cycle pulse: request accepted
- rd_word_valid  out  1  one refill word delivered this cycle
- rd_word_idx  out  IW  word index in line, IW=clog2(LINE_WORDS)
- rd_word_data  out  32  refill word
- rd_done  out  1  1-cycle pulse: burst complete
- rd_err  out  1  valid with rd_done: any rresp!=0
- wr_req  in  1  write-back request; level, held until wr_ack
- wr_addr  in  32  write-back byte address
- wr_ack  out  1  1-cycle pulse: request accepted
- wr_word_idx  out  IW  index of the cache word to supply
- wr_word_data  in  32  cache word at wr_word_idx, same cycle (combinational)
- wr_done  out  1  1-cycle pulse: B response received
- wr_err  out  1  valid with wr_done: bresp!=0
- ar*/r*/aw*/w*/b*  standard AXI3 32-bit master ports: arid..arready, rid..rready, awid..awready, wid..wready, bid..bready

Behaviour:
- Reset, and on reset asserted mid-transfer: both FSMs idle; arvalid, rready, awvalid, wvalid, wlast, bready, rd_ack, rd_word_valid, rd_done, rd_err, wr_ack, wr_done, wr_err all 0; beat counters 0. Any in-flight burst is abandoned with no done pulse.
- Constant outputs:
  - arlen = awlen = LINE_WORDS-1
  - arsize = awsize = 3'b010
  - arburst = awburst = 2'b01
  - lock/cache/prot = 0
  - wstrb = 4'hF
  - arid = RD_ID; awid = wid = WR_ID
- Addresses are line-aligned: the low clog2(LINE_WORDS)+2 bits are cleared when latched.
- Read FSM R_IDLE -> R_AR -> R_DATA -> R_IDLE:
  - R_IDLE: if rd_req and not blocked, latch aligned address, pulse rd_ack, go to R_AR.
    - Blocked when the write FSM is not W_IDLE and the aligned rd_addr equals the latched write line address.
    - Also blocked when the same-line wr_req is being accepted that cycle; write has priority.
  - R_AR: arvalid=1, araddr held stable. Leave on arvalid&&arready.
  - R_DATA: rready=1. On each rvalid&&rready:
    - rd_word_valid=1 the same cycle; rd_word_idx = beat counter; rd_word_data = rdata.
    - counter increments; rresp!=0 sets the sticky error flag.
  - Exit R_DATA on the beat with rlast=1 or counter==LINE_WORDS-1. That cycle: rd_done=1, rd_err = sticky OR current-beat error. Sticky flag cleared on entry to R_AR.
  - rid is not checked.
- Write FSM W_IDLE -> W_BURST -> W_RESP -> W_IDLE:
  - W_IDLE: if wr_req, latch aligned address, pulse wr_ack, set awvalid=1 and wvalid=1 from the next cycle.
  - W_BURST: AW and W proceed independently.
    - awvalid drops after the AW handshake; aw_done flag set.
    - wdata = wr_word_data with wr_word_idx = beat counter. The counter advances on wvalid&&wready.
    - wlast=1 exactly when counter==LINE_WORDS-1. wvalid drops after the last handshake.
    - Go to W_RESP once both AW and the last W handshake are complete, in either order or the same cycle.
  - W_RESP: bready=1. On bvalid: wr_done=1, wr_err=(bresp!=0), go to W_IDLE.
- Simultaneous rd_req and wr_req to different lines: both are accepted in the same cycle.
- rd_ack and wr_ack are never asserted in R/W states other than idle. Requests are ignored while busy.
- LINE_WORDS counter wraps naturally at IW bits. No partial bursts.

Test Plan:
- LINE_WORDS=8. rd_req with addr 0x1000_0014, arready after 2 cycles, 8 beats with data 0xA0..0xA7 and rvalid gaps. Required:
  - araddr = 0x1000_0000, arlen = 7.
  - rd_word_idx 0..7 carry the matching data.
  - rd_done once, on the 8th beat, with rd_err=0.
- Write-back 0x2000_0020 with awready delayed 5 cycles beyond the last W beat. Required:
  - wdata follows wr_word_idx 0..7; wlast only on beat 7.
  - bready only after both channels complete; wr_done with bresp=0 gives wr_err=0.
- rresp=2'b10 on beat 3 only -> rd_err=1 at rd_done. bresp=2'b10 -> wr_err=1.
- wr_req line 0x3000_0000 in flight, rd_req 0x3000_0008 -> no rd_ack until the cycle after wr_done. A rd_req to 0x4000_0000 is acked immediately.
- aresetn pulsed high during read beat 4 -> next cycle all valid/ready outputs 0 and FSMs idle. No rd_done. A new rd_req is acked normally.
- LINE_WORDS=16 regression -> arlen = awlen = 15, 16 beats, idx wraps to 0 afterwards.

Source files
------------

// File: rtl/axi_line_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_line_master
// Purpose  : AXI3 cache-line burst master. The read engine fetches one INCR
//            burst per refill and streams the words to the cache. The write
//            engine reads the line from the cache array by index, issues a
//            full INCR write burst and tracks the B response. A refill of the
//            line currently being written back is held off.
// Revision : 1.0 - initial release
// ============================================================================
module axi_line_master #(
    parameter int LINE_WORDS = 8,
    parameter int RD_ID      = 0,
    parameter int WR_ID      = 1,
    parameter int ID_WIDTH   = 4
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    // refill request side
    input  logic                            rd_req,
    input  logic [31:0]                     rd_addr,
    output logic                            rd_ack,
    output logic                            rd_word_valid,
    output logic [$clog2(LINE_WORDS)-1:0]   rd_word_idx,
    output logic [31:0]                     rd_word_data,
    output logic                            rd_done,
    output logic                            rd_err,
    // write-back request side
    input  logic                            wr_req,
    input  logic [31:0]                     wr_addr,
    output logic                            wr_ack,
    output logic [$clog2(LINE_WORDS)-1:0]   wr_word_idx,
    input  logic [31:0]                     wr_word_data,
    output logic                            wr_done,
    output logic                            wr_err,
    // AXI3 read address channel
    output logic [ID_WIDTH-1:0]             arid,
    output logic [31:0]                     araddr,
    output logic [3:0]                      arlen,
    output logic [2:0]                      arsize,
    output logic [1:0]                      arburst,
    output logic [1:0]                      arlock,
    output logic [3:0]                      arcache,
    output logic [2:0]                      arprot,
    output logic                            arvalid,
    input  logic                            arready,
    // AXI3 read data channel
    input  logic [ID_WIDTH-1:0]             rid,
    input  logic [31:0]                     rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rlast,
    input  logic                            rvalid,
    output logic                            rready,
    // AXI3 write address channel
    output logic [ID_WIDTH-1:0]             awid,
    output logic [31:0]                     awaddr,
    output logic [3:0]                      awlen,
    output logic [2:0]                      awsize,
    output logic [1:0]                      awburst,
    output logic [1:0]                      awlock,
    output logic [3:0]                      awcache,
    output logic [2:0]                      awprot,
    output logic                            awvalid,
    input  logic                            awready,
    // AXI3 write data channel
    output logic [ID_WIDTH-1:0]             wid,
    output logic [31:0]                     wdata,
    output logic [3:0]                      wstrb,
    output logic                            wlast,
    output logic                            wvalid,
    input  logic                            wready,
    // AXI3 write response channel
    input  logic [ID_WIDTH-1:0]             bid,
    input  logic [1:0]                      bresp,
    input  logic                            bvalid,
    output logic                            bready
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int AL = IW + 2;     // byte-offset bits inside one line
    localparam logic [IW-1:0] c_last_beat = IW'(LINE_WORDS - 1);

    localparam logic [1:0] c_r_idle  = 2'd0;
    localparam logic [1:0] c_r_ar    = 2'd1;
    localparam logic [1:0] c_r_data  = 2'd2;

    localparam logic [1:0] c_w_idle  = 2'd0;
    localparam logic [1:0] c_w_burst = 2'd1;
    localparam logic [1:0] c_w_resp  = 2'd2;

    logic [1:0]    r_rstate;
    logic [1:0]    r_wstate;
    logic [31:0]   r_rd_line;
    logic [31:0]   r_wr_line;
    logic [IW-1:0] r_rd_cnt;
    logic [IW-1:0] r_wr_cnt;
    logic          r_rd_err;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_aw_done;

    logic [31:0]   w_rd_line;
    logic [31:0]   w_wr_line;
    logic          w_wr_accept;
    logic          w_rd_blocked;
    logic          w_rd_accept;
    logic          w_r_beat;
    logic          w_r_last;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_aw_fin;
    logic          w_w_fin;
    logic          w_b_hs;
    logic          w_unused_inputs;

    assign w_rd_line = {rd_addr[31:AL], {AL{1'b0}}};
    assign w_wr_line = {wr_addr[31:AL], {AL{1'b0}}};

    // Write-back wins a same-line race; the refill must wait for it to land.
    assign w_wr_accept  = !aresetn && (r_wstate == c_w_idle) && wr_req;
    assign w_rd_blocked = ((r_wstate != c_w_idle) && (w_rd_line == r_wr_line)) ||
                          (w_wr_accept && (w_rd_line == w_wr_line));
    assign w_rd_accept  = !aresetn && (r_rstate == c_r_idle) && rd_req && !w_rd_blocked;

    assign w_r_beat = !aresetn && (r_rstate == c_r_data) && rvalid;
    assign w_r_last = w_r_beat && (rlast || (r_rd_cnt == c_last_beat));

    assign w_aw_hs  = r_awvalid && awready;
    assign w_w_hs   = r_wvalid && wready;
    // wvalid is raised on entry to the burst, so a low wvalid means all beats went
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = !r_wvalid || (w_w_hs && (r_wr_cnt == c_last_beat));
    assign w_b_hs   = !aresetn && (r_wstate == c_w_resp) && bvalid;

    // IDs and sub-line address bits carry no information for this master
    assign w_unused_inputs = ^{rid, bid, rd_addr[AL-1:0], wr_addr[AL-1:0]};

    // Read engine: address phase, then data beats until the last word
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            r_rstate  <= c_r_idle;
            r_rd_line <= '0;
            r_rd_cnt  <= '0;
            r_rd_err  <= 1'b0;
        end else begin
            case (r_rstate)
                c_r_idle: begin
                    if (w_rd_accept) begin
                        r_rd_line <= w_rd_line;
                        r_rd_cnt  <= '0;
                        r_rd_err  <= 1'b0;
                        r_rstate  <= c_r_ar;
                    end
                end
                c_r_ar: begin
                    if (arready) begin
                        r_rstate <= c_r_data;
                    end
                end
                c_r_data: begin
                    if (w_r_beat) begin
                        if (rresp != 2'b00) begin
                            r_rd_err <= 1'b1;
                        end
                        if (w_r_last) begin
                            r_rd_cnt <= '0;
                            r_rstate <= c_r_idle;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + IW'(1);
                        end
                    end
                end
                default: r_rstate <= c_r_idle;
            endcase
        end
    end

    // Write engine: AW and W run independently, then wait for B
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            r_wstate  <= c_w_idle;
            r_wr_line <= '0;
            r_wr_cnt  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
        end else begin
            case (r_wstate)
                c_w_idle: begin
                    if (w_wr_accept) begin
                        r_wr_line <= w_wr_line;
                        r_wr_cnt  <= '0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_wstate  <= c_w_burst;
                    end
                end
                c_w_burst: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wr_cnt <= r_wr_cnt + IW'(1);
                        if (r_wr_cnt == c_last_beat) begin
                            r_wvalid <= 1'b0;
                        end
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_wstate <= c_w_resp;
                    end
                end
                c_w_resp: begin
                    if (w_b_hs) begin
                        r_wstate <= c_w_idle;
                    end
                end
                default: r_wstate <= c_w_idle;
            endcase
        end
    end

    // Cache-side handshakes and beat reporting
    assign rd_ack        = w_rd_accept;
    assign rd_word_valid = w_r_beat;
    assign rd_word_idx   = r_rd_cnt;
    assign rd_word_data  = rdata;
    assign rd_done       = w_r_last;
    assign rd_err        = w_r_last && (r_rd_err || (rresp != 2'b00));

    assign wr_ack        = w_wr_accept;
    assign wr_word_idx   = r_wr_cnt;
    assign wr_done       = w_b_hs;
    assign wr_err        = w_b_hs && (bresp != 2'b00);

    // AXI read side
    assign arid    = ID_WIDTH'(RD_ID);
    assign araddr  = r_rd_line;
    assign arlen   = 4'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (r_rstate == c_r_ar);
    assign rready  = (r_rstate == c_r_data);

    // AXI write side
    assign awid    = ID_WIDTH'(WR_ID);
    assign awaddr  = r_wr_line;
    assign awlen   = 4'(LINE_WORDS - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = r_awvalid;
    assign wid     = ID_WIDTH'(WR_ID);
    assign wdata   = wr_word_data;
    assign wstrb   = 4'hF;
    assign wlast   = r_wvalid && (r_wr_cnt == c_last_beat);
    assign wvalid  = r_wvalid;
    assign bready  = (r_wstate == c_w_resp);

endmodule
`default_nettype wire

// File: tb/tb_axi_line_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_line_master
// Purpose  : Self-checking bench for axi_line_master (8-word and 16-word lines)
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_line_master;

    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 8-word instance ----------------
    logic        aresetn;
    logic        rd_req, rd_ack, rd_word_valid, rd_done, rd_err;
    logic [31:0] rd_addr, rd_word_data;
    logic [2:0]  rd_word_idx;
    logic        wr_req, wr_ack, wr_done, wr_err;
    logic [31:0] wr_addr, wr_word_data;
    logic [2:0]  wr_word_idx;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    logic [31:0] cache [LW];
    logic [31:0] beat_data [LW];
    logic [1:0]  beat_resp [LW];
    assign wr_word_data = cache[wr_word_idx];

    axi_line_master #(.LINE_WORDS(8), .RD_ID(0), .WR_ID(1)) dut8 (
        .aclk(clk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_word_valid(rd_word_valid), .rd_word_idx(rd_word_idx),
        .rd_word_data(rd_word_data), .rd_done(rd_done), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .wr_word_idx(wr_word_idx), .wr_word_data(wr_word_data),
        .wr_done(wr_done), .wr_err(wr_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // ---------------- 16-word instance ----------------
    logic        h_rd_req, h_rd_ack, h_rd_word_valid, h_rd_done, h_rd_err;
    logic [31:0] h_rd_addr, h_rd_word_data;
    logic [3:0]  h_rd_word_idx;
    logic        h_wr_req, h_wr_ack, h_wr_done, h_wr_err;
    logic [31:0] h_wr_addr, h_wr_word_data;
    logic [3:0]  h_wr_word_idx;
    logic [3:0]  h_arid, h_awid, h_wid;
    logic [31:0] h_araddr, h_awaddr, h_rdata, h_wdata;
    logic [3:0]  h_arlen, h_awlen, h_arcache, h_awcache, h_wstrb;
    logic [2:0]  h_arsize, h_awsize, h_arprot, h_awprot;
    logic [1:0]  h_arburst, h_awburst, h_arlock, h_awlock;
    logic        h_arvalid, h_arready, h_rlast, h_rvalid, h_rready;
    logic        h_awvalid, h_awready, h_wlast, h_wvalid, h_wready, h_bvalid, h_bready;

    assign h_wr_word_data = {16'hC0DE, 12'h000, h_wr_word_idx};

    axi_line_master #(.LINE_WORDS(16), .RD_ID(0), .WR_ID(1)) dut16 (
        .aclk(clk), .aresetn(aresetn),
        .rd_req(h_rd_req), .rd_addr(h_rd_addr), .rd_ack(h_rd_ack),
        .rd_word_valid(h_rd_word_valid), .rd_word_idx(h_rd_word_idx),
        .rd_word_data(h_rd_word_data), .rd_done(h_rd_done), .rd_err(h_rd_err),
        .wr_req(h_wr_req), .wr_addr(h_wr_addr), .wr_ack(h_wr_ack),
        .wr_word_idx(h_wr_word_idx), .wr_word_data(h_wr_word_data),
        .wr_done(h_wr_done), .wr_err(h_wr_err),
        .arid(h_arid), .araddr(h_araddr), .arlen(h_arlen), .arsize(h_arsize),
        .arburst(h_arburst), .arlock(h_arlock), .arcache(h_arcache), .arprot(h_arprot),
        .arvalid(h_arvalid), .arready(h_arready),
        .rid(4'h0), .rdata(h_rdata), .rresp(2'b00), .rlast(h_rlast),
        .rvalid(h_rvalid), .rready(h_rready),
        .awid(h_awid), .awaddr(h_awaddr), .awlen(h_awlen), .awsize(h_awsize),
        .awburst(h_awburst), .awlock(h_awlock), .awcache(h_awcache), .awprot(h_awprot),
        .awvalid(h_awvalid), .awready(h_awready),
        .wid(h_wid), .wdata(h_wdata), .wstrb(h_wstrb), .wlast(h_wlast),
        .wvalid(h_wvalid), .wready(h_wready),
        .bid(4'h0), .bresp(2'b00), .bvalid(h_bvalid), .bready(h_bready)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    // Every task starts at a negedge, drives that cycle, samples #1 later,
    // and returns at the negedge that begins the following cycle.
    task automatic rd_request(input logic [31:0] addr, input int exp_wait);
        int  waited;
        bit  got;
        waited = 0;
        got    = 0;
        rd_req  = 1'b1;
        rd_addr = addr;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (rd_ack === 1'b1) got = 1;
            else waited++;
            @(negedge clk);
        end
        rd_req = 1'b0;
        chk("rd_ack_seen", 32'(got), 1);
        chk("rd_ack_wait", waited, exp_wait);
    endtask

    task automatic wr_request(input logic [31:0] addr);
        wr_req  = 1'b1;
        wr_addr = addr;
        #1;
        chk("wr_ack", wr_ack, 1);
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic rd_body(input logic [31:0] exp_line, input int ar_delay,
                           input int gap_pct, input int rst_beat, input logic exp_err);
        for (int c = 0; c <= ar_delay; c++) begin
            arready = (c == ar_delay);
            #1;
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, exp_line);
            chk("rready_in_ar", rready, 0);
            @(negedge clk);
        end
        arready = 1'b0;
        for (int b = 0; b < LW; b++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                #1;
                chk("rd_word_valid_gap", rd_word_valid, 0);
                chk("rready", rready, 1);
                @(negedge clk);
            end
            rvalid = 1'b1;
            rdata  = beat_data[b];
            rresp  = beat_resp[b];
            rlast  = (b == LW - 1);
            if (b == rst_beat) aresetn = 1'b1;
            #1;
            if (b == rst_beat) begin
                chk("rd_done_in_reset", rd_done, 0);
                @(negedge clk);
                aresetn = 1'b0;
                rvalid  = 1'b0;
                rlast   = 1'b0;
                rresp   = 2'b00;
                #1;
                chk("idle_after_reset",
                    {arvalid, rready, awvalid, wvalid, wlast, bready, rd_ack, rd_word_valid,
                     rd_done, rd_err, wr_ack, wr_done, wr_err}, 0);
                chk("rd_idx_after_reset", rd_word_idx, 0);
                @(negedge clk);
                return;
            end
            chk("rd_word_valid", rd_word_valid, 1);
            chk("rd_word_idx", rd_word_idx, b);
            chk("rd_word_data", rd_word_data, beat_data[b]);
            chk("rd_done", rd_done, (b == LW - 1));
            if (b == LW - 1) chk("rd_err", rd_err, exp_err);
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
        #1;
        chk("rready_after", rready, 0);
        chk("rd_done_after", rd_done, 0);
        chk("rd_idx_after", rd_word_idx, 0);
        @(negedge clk);
    endtask

    // rd_mode: 0 no read traffic, 1 same-line rd_req held (must stay blocked),
    //          2 other-line rd_req held (must be acked in the first burst cycle)
    task automatic wr_body(input logic [31:0] exp_line, input int aw_at, input int wready_pct,
                           input int b_delay, input logic [1:0] bresp_v, input logic exp_err,
                           input int rd_mode);
        int cyc;
        int wbeat;
        bit aw_ok;
        cyc   = 0;
        wbeat = 0;
        aw_ok = 0;
        while (!(aw_ok && wbeat == LW) && cyc < 200) begin
            awready = (cyc >= aw_at);
            wready  = ($urandom_range(99) < wready_pct);
            #1;
            chk("awvalid", awvalid, 32'(!aw_ok));
            if (!aw_ok) chk("awaddr", awaddr, exp_line);
            chk("wvalid", wvalid, (wbeat < LW));
            chk("wlast", wlast, (wbeat == LW - 1));
            if (wbeat < LW) begin
                chk("wr_word_idx", wr_word_idx, wbeat);
                chk("wdata", wdata, cache[wbeat]);
            end
            chk("bready_early", bready, 0);
            if (rd_mode == 1) chk("rd_ack_blocked", rd_ack, 0);
            if (rd_mode == 2 && cyc == 0) chk("rd_ack_other_line", rd_ack, 1);
            if (awready && !aw_ok) aw_ok = 1;
            if (wready && wbeat < LW) wbeat++;
            @(negedge clk);
            if (rd_mode == 2 && cyc == 0) rd_req = 1'b0;
            cyc++;
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk("w_phase_complete", 32'(aw_ok && wbeat == LW), 1);
        for (int c = 0; c <= b_delay; c++) begin
            bvalid = (c == b_delay);
            bresp  = bresp_v;
            #1;
            chk("bready", bready, 1);
            chk("aw_w_quiet", {awvalid, wvalid, wlast}, 0);
            chk("wr_done", wr_done, (c == b_delay));
            if (c == b_delay) chk("wr_err", wr_err, exp_err);
            if (rd_mode == 1) chk("rd_ack_blocked_resp", rd_ack, 0);
            @(negedge clk);
        end
        bvalid = 1'b0;
        bresp  = 2'b00;
        #1;
        chk("bready_after", bready, 0);
        chk("wr_done_after", wr_done, 0);
        chk("wr_idx_after", wr_word_idx, 0);
        if (rd_mode == 1) chk("rd_ack_after_wr_done", rd_ack, 1);
        @(negedge clk);
        if (rd_mode == 1) rd_req = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] exp_line;
        int          bad_beat;   // read: beat with rresp=SLVERR; write: >=0 gives bresp=SLVERR
        int          delay;      // read: arready delay; write: cycle awready rises
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 32'h1000_0014, 32'h1000_0000, -1, 2,  1'b0};
        vecs[1] = '{0, 32'h1000_0034, 32'h1000_0020,  3, 0,  1'b1};
        vecs[2] = '{0, 32'h1000_0040, 32'h1000_0040, -1, 1,  1'b0};
        vecs[3] = '{1, 32'h2000_0020, 32'h2000_0020, -1, 12, 1'b0};
        vecs[4] = '{1, 32'h2000_003C, 32'h2000_0020,  0, 0,  1'b1};
        vecs[5] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, -1, 7,  1'b0};
        vecs[6] = '{0, 32'h0000_001F, 32'h0000_0000, -1, 3,  1'b0};
        vecs[7] = '{1, 32'h2000_0000, 32'h2000_0000, -1, 3,  1'b0};

        aresetn = 1'b1;
        rd_req = 0; rd_addr = 0; wr_req = 0; wr_addr = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        h_rd_req = 0; h_rd_addr = 0; h_wr_req = 0; h_wr_addr = 0;
        h_arready = 0; h_rdata = 0; h_rlast = 0; h_rvalid = 0;
        h_awready = 0; h_wready = 0; h_bvalid = 0;
        for (int i = 0; i < LW; i++) begin
            cache[i] = 0; beat_data[i] = 0; beat_resp[i] = 0;
        end

        repeat (3) @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("reset_idle",
            {arvalid, rready, awvalid, wvalid, wlast, bready, rd_ack, rd_word_valid,
             rd_done, rd_err, wr_ack, wr_done, wr_err}, 0);
        chk("reset_counters", {rd_word_idx, wr_word_idx}, 0);
        chk("const_len", {arlen, awlen}, {4'd7, 4'd7});
        chk("const_size_burst", {arsize, awsize, arburst, awburst}, {3'b010, 3'b010, 2'b01, 2'b01});
        chk("const_zero_attr", {arlock, arcache, arprot, awlock, awcache, awprot}, 0);
        chk("const_ids_strb", {arid, awid, wid, wstrb}, {4'd0, 4'd1, 4'd1, 4'hF});
        @(negedge clk);

        // table-driven single transactions
        for (int v = 0; v < 8; v++) begin
            if (!vecs[v].is_wr) begin
                for (int b = 0; b < LW; b++) begin
                    beat_data[b] = 32'hA0 + b + (v << 8);
                    beat_resp[b] = (b == vecs[v].bad_beat) ? 2'b10 : 2'b00;
                end
                rd_request(vecs[v].addr, 0);
                rd_body(vecs[v].exp_line, vecs[v].delay, 40, -1, vecs[v].exp_err);
            end else begin
                for (int b = 0; b < LW; b++) cache[b] = 32'hD000_0000 + (v << 12) + b * 32'h11;
                wr_request(vecs[v].addr);
                wr_body(vecs[v].exp_line, vecs[v].delay, (v == 4) ? 50 : 100, v % 3,
                        (vecs[v].bad_beat >= 0) ? 2'b10 : 2'b00, vecs[v].exp_err, 0);
            end
        end

        // same-line refill held off until the write-back completes
        for (int b = 0; b < LW; b++) begin
            cache[b] = 32'h3300_0000 + b; beat_data[b] = 32'h3A00_0000 + b; beat_resp[b] = 0;
        end
        wr_request(32'h3000_0000);
        rd_req = 1'b1; rd_addr = 32'h3000_0008;
        wr_body(32'h3000_0000, 2, 100, 2, 2'b00, 1'b0, 1);
        rd_body(32'h3000_0000, 0, 0, -1, 1'b0);

        // other-line refill accepted while a write-back is in flight
        wr_request(32'h3000_0000);
        rd_req = 1'b1; rd_addr = 32'h4000_0000;
        wr_body(32'h3000_0000, 4, 70, 1, 2'b00, 1'b0, 2);
        rd_body(32'h4000_0000, 1, 20, -1, 1'b0);

        // same-cycle requests: same line -> write only; different lines -> both
        rd_req = 1'b1; rd_addr = 32'h3100_0010;
        wr_req = 1'b1; wr_addr = 32'h3100_0004;
        #1;
        chk("same_line_wr_ack", wr_ack, 1);
        chk("same_line_rd_ack", rd_ack, 0);
        @(negedge clk);
        wr_req = 1'b0;
        wr_body(32'h3100_0000, 0, 100, 0, 2'b00, 1'b0, 1);
        rd_body(32'h3100_0000, 0, 0, -1, 1'b0);

        rd_req = 1'b1; rd_addr = 32'h4400_0040;
        wr_req = 1'b1; wr_addr = 32'h5500_0000;
        #1;
        chk("dual_accept", {rd_ack, wr_ack}, 2'b11);
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        wr_body(32'h5500_0000, 1, 100, 0, 2'b01, 1'b1, 0);
        rd_body(32'h4400_0040, 0, 0, -1, 1'b0);

        // reset in the middle of a refill, then a clean refill
        for (int b = 0; b < LW; b++) begin beat_data[b] = 32'h6000_0000 + b; beat_resp[b] = 0; end
        rd_request(32'h6000_0000, 0);
        rd_body(32'h6000_0000, 0, 0, 4, 1'b0);
        rd_request(32'h6000_0000, 0);
        rd_body(32'h6000_0000, 1, 30, -1, 1'b0);

        // randomized traffic against the reference rules
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            logic        e;
            logic [1:0]  br;
            a = $urandom;
            if ($urandom_range(1) == 1) begin
                e = 1'b0;
                for (int b = 0; b < LW; b++) begin
                    beat_data[b] = $urandom;
                    beat_resp[b] = ($urandom_range(9) == 0) ? 2'b10 : 2'b00;
                    e = e | (beat_resp[b] != 2'b00);
                end
                rd_request(a, 0);
                rd_body(line_of(a), $urandom_range(3), $urandom_range(50), -1, e);
            end else begin
                for (int b = 0; b < LW; b++) cache[b] = $urandom;
                br = ($urandom_range(3) == 0) ? 2'b10 : 2'b00;
                wr_request(a);
                wr_body(line_of(a), $urandom_range(12), $urandom_range(40, 100),
                        $urandom_range(3), br, (br != 2'b00), 0);
            end
        end

        // 16-word line instance
        chk("h_len", {h_arlen, h_awlen}, {4'd15, 4'd15});
        h_rd_req = 1'b1; h_rd_addr = 32'h7000_0044;
        #1;
        chk("h_rd_ack", h_rd_ack, 1);
        @(negedge clk);
        h_rd_req = 1'b0; h_arready = 1'b1;
        #1;
        chk("h_araddr", {31'(h_araddr >> 1), h_arvalid}, {31'(32'h7000_0040 >> 1), 1'b1});
        @(negedge clk);
        h_arready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            h_rvalid = 1'b1; h_rdata = b * 3 + 1; h_rlast = (b == 15);
            #1;
            chk("h_rd_beat", {h_rd_word_valid, h_rd_word_idx, h_rd_done},
                {1'b1, 4'(b), (b == 15)});
            chk("h_rd_data", h_rd_word_data, b * 3 + 1);
            @(negedge clk);
        end
        h_rvalid = 1'b0; h_rlast = 1'b0;
        #1;
        chk("h_rd_after", {h_rready, h_rd_word_idx, h_rd_done}, 0);
        @(negedge clk);
        h_wr_req = 1'b1; h_wr_addr = 32'h7000_0080;
        #1;
        chk("h_wr_ack", h_wr_ack, 1);
        @(negedge clk);
        h_wr_req = 1'b0; h_awready = 1'b1; h_wready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            #1;
            chk("h_w_beat", {h_wvalid, h_wr_word_idx, h_wlast}, {1'b1, 4'(b), (b == 15)});
            chk("h_wdata", h_wdata, {16'hC0DE, 12'h000, 4'(b)});
            @(negedge clk);
        end
        h_awready = 1'b0; h_wready = 1'b0; h_bvalid = 1'b1;
        #1;
        chk("h_resp", {h_bready, h_wvalid, h_wr_word_idx, h_wr_done, h_wr_err},
            {1'b1, 1'b0, 4'd0, 1'b1, 1'b0});
        @(negedge clk);
        h_bvalid = 1'b0;
        #1;
        chk("h_idle", {h_bready, h_wr_done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
